mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  EX/MEM and MEM/WB pipeline registers around the 16x4 data memory.
//  - Latches execute-stage results and drives the data memory's write-enable, address and write-data from the EX/MEM register.
//  - Captures the memory's asynchronous read data (or the ALU result) into MEM/WB for register write-back.
//  - Raises a load-use stall toward decode; freezes on stall and bubbles on flush.
// PARAMETERS
//  DW  4  data width (matches data memory word)
//  AW  4  data memory address width
//  RW  2  register-file index width
// PORTS
//  clk            in   1   rising-edge clock, single domain
//  rst_n          in   1   synchronous active-low reset
//  ex_valid       in   1   EX stage holds a real instruction
//  ex_alu         in   DW  ALU result / memory address
//  ex_sdata       in   DW  store data
//  ex_mem_we      in   1   instruction is a store
//  ex_mem_re      in   1   instruction is a load
//  ex_rd          in   RW  destination register
//  ex_reg_we      in   1   instruction writes a register
//  id_rs1,id_rs2  in   RW  decode-stage source registers
//  stall          in   1   global hold request from the hazard unit
//  flush          in   1   squash the instruction entering EX/MEM
//  dmem_we        out  1   data memory write enable
//  dmem_addr      out  AW  data memory address = EX/MEM alu[AW-1:0]
//  dmem_di        out  DW  data memory write data
//  dmem_do        in   DW  data memory asynchronous read data
//  load_use       out  1   decode must stall one cycle
//  wb_valid       out  1   MEM/WB holds a real instruction
//  wb_reg_we      out  1   register write strobe (= wb_valid & stored reg_we)
//  wb_rd          out  RW  write-back register index
//  wb_data        out  DW  write-back data
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all valid bits, EX/MEM and MEM/WB fields cleared to 0.
//  - Outputs while in reset: dmem_we=0, wb_valid=0, wb_reg_we=0, load_use=0, dmem_addr=0, dmem_di=0, wb_rd=0, wb_data=0.
//  - Reset wins over stall and flush.
//  EX/MEM update at posedge:
//  - stall=1: hold all fields.
//  - else flush=1: valid<=0; other fields don't-care but are zeroed.
//  - else: capture all ex_* fields; valid<=ex_valid.
//  MEM/WB update at posedge:
//  - stall=1: hold.
//  - else: valid<=EX/MEM valid; rd and reg_we copied; data <= dmem_do if EX/MEM is a load, otherwise EX/MEM alu.
//  Memory interface (combinational from EX/MEM): dmem_we = mem_valid & mem_we & ~stall.
//  - A frozen store therefore writes exactly once: on its first unfrozen edge.
//  - A store with ex_valid=0 or a flushed store never writes.
//  Latency: ex_* at edge N -> memory access during cycle N..N+1 -> wb_* valid after edge N+1 (2 edges EX->WB).
//  load_use (combinational) = mem_valid & mem_re & mem_reg_we & (mem_rd==id_rs1 | mem_rd==id_rs2).
//  Simultaneous stall & flush: stall wins (the instruction is held, not squashed).
//  Load and store to the same address in consecutive cycles: the load in EX/MEM reads the pre-edge word; the store lands at its edge.
//  Address wraps modulo 2^AW. No arithmetic is done here; widths pass through.
//  Invariant: mem_we & mem_re both set is illegal; treat as a store (write occurs, data captured = alu).
// CONFIGURATION
//  MEM_FWD_EN defined:
//  - If EX/MEM is a store and MEM/WB has wb_reg_we with wb_rd == the store's source register, dmem_di = wb_data instead of the latched sdata.
//  - Adds input ex_srs [RW-1:0] (store source register), latched in EX/MEM.
//  MEM_FWD_EN undefined: dmem_di = latched sdata; port ex_srs absent.
// TESTING
//  Reset: rst_n=0 two cycles with ex_valid=1, ex_mem_we=1 -> dmem_we=0, wb_valid=0, all outputs 0.
//  Store: ex_valid=1, we=1, alu=4'h5, sdata=4'hA -> next cycle dmem_we=1, addr=5, di=A; mem[5]=A after the following edge; wb_reg_we=0.
//  Load: mem[3]=4'h9; load alu=3, rd=2, reg_we=1 -> 2 edges later wb_valid=1, wb_rd=2, wb_data=9.
//  Load-use: load rd=1 in EX/MEM, id_rs2=1 -> load_use=1; id_rs1=id_rs2=0 -> load_use=0.
//  Stall on store: store in EX/MEM, stall=1 for 3 cycles -> dmem_we=0 throughout; then 1 write; MEM/WB unchanged while stalled.
//  Flush vs stall: flush=1 with a store at EX -> no write, wb_valid=0 next; stall=1 & flush=1 -> instruction held, valid stays 1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers around the 16x4 data memory.
// Optional store-data forwarding from write-back is enabled by defining MEM_FWD_EN.
module mem_wb_stage #(
  parameter int DW = 4,
  parameter int AW = 4,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu,
  input  logic [DW-1:0] ex_sdata,
  input  logic          ex_mem_we,
  input  logic          ex_mem_re,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_we,
`ifdef MEM_FWD_EN
  input  logic [RW-1:0] ex_srs,
`endif
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          stall,
  input  logic          flush,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_di,
  input  logic [DW-1:0] dmem_do,
  output logic          load_use,
  output logic          wb_valid,
  output logic          wb_reg_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data
);

  logic          mem_valid;
  logic [DW-1:0] mem_alu;
  logic [DW-1:0] mem_sdata;
  logic          mem_we;
  logic          mem_re;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_we;
  logic          wb_rwe;
  logic          mem_load;
`ifdef MEM_FWD_EN
  logic [RW-1:0] mem_srs;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid  <= 1'b0;
      mem_alu    <= '0;
      mem_sdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_rd     <= '0;
      mem_reg_we <= 1'b0;
`ifdef MEM_FWD_EN
      mem_srs    <= '0;
`endif
    end else if (stall) begin
      mem_valid <= mem_valid;
    end else if (flush) begin
      mem_valid  <= 1'b0;
      mem_alu    <= '0;
      mem_sdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_rd     <= '0;
      mem_reg_we <= 1'b0;
`ifdef MEM_FWD_EN
      mem_srs    <= '0;
`endif
    end else begin
      mem_valid  <= ex_valid;
      mem_alu    <= ex_alu;
      mem_sdata  <= ex_sdata;
      mem_we     <= ex_mem_we;
      mem_re     <= ex_mem_re;
      mem_rd     <= ex_rd;
      mem_reg_we <= ex_reg_we;
`ifdef MEM_FWD_EN
      mem_srs    <= ex_srs;
`endif
    end
  end

  // A load that is also flagged as a store is treated as a store.
  assign mem_load = mem_re & ~mem_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rwe   <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (!stall) begin
      wb_valid <= mem_valid;
      wb_rwe   <= mem_reg_we;
      wb_rd    <= mem_rd;
      wb_data  <= mem_load ? dmem_do : mem_alu;
    end
  end

  assign wb_reg_we = wb_valid & wb_rwe;
  assign dmem_we   = mem_valid & mem_we & ~stall;
  assign dmem_addr = mem_alu[AW-1:0];

`ifdef MEM_FWD_EN
  always_comb begin
    dmem_di = mem_sdata;
    if (mem_we && wb_reg_we && (wb_rd == mem_srs))
      dmem_di = wb_data;
  end
`else
  assign dmem_di = mem_sdata;
`endif

  assign load_use = mem_valid & mem_re & mem_reg_we &
                    ((mem_rd == id_rs1) | (mem_rd == id_rs2));

endmodule
